// File: rtl/serial_add_sub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The master issues operands and start; the slave returns status, result and flags.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cy_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cy_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cy_out, overflow
    );
endinterface

// File: rtl/serial_add_sub_unit.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice plus a carry
// flop processes one bit per clock, LSB first, with a start/busy/done handshake.
module serial_add_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_sub_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic             cy_q, cy_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_bit;

    // The single full-adder slice.
    always_comb begin
        s_bit = sa_q[0] ^ sb_q[0] ^ carry_q;
        c_bit = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    end

    always_comb begin
        // NOTE: every signal takes its held value first so no path leaves one unassigned (no latches).
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        cy_d    = cy_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    sa_d    = bus.a;
                    sb_d    = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = c_bit;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_MSB_IN) begin
                    c_msb_d = c_bit;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cy_d    = c_bit;
                    ovf_d   = c_msb_q ^ c_bit;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            // NOTE: the operand shift registers are reset too; they are plain flops, not a memory array.
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cy_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            cy_q    <= cy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = res_q;
    assign bus.cy_out   = cy_q;
    assign bus.overflow = ovf_q;

endmodule
